// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencing over a
// single handshaked memory port, with illegal-instruction and memory-timeout traps.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction_code,
  input  logic             branch_taken,
  input  logic             mem_ready,
  input  logic             trap_clear,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       MemtoReg,
  output logic             ALUSrc,
  output logic [4:0]       ALUControl,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic             instr_retired,
  output logic [CNT_W-1:0] instret_count
);

  localparam logic [6:0] OP_R = 7'b0110011, OP_I_ARITH = 7'b0010011, OP_I_LOAD = 7'b0000011,
                         OP_S = 7'b0100011, OP_B = 7'b1100011, OP_J_JAL = 7'b1101111,
                         OP_I_JALR = 7'b1100111, OP_U_LUI = 7'b0110111, OP_U_AUIPC = 7'b0010111;

  localparam logic [4:0] ALU_NOP = 5'd0, ALU_ADD = 5'd1, ALU_SUB = 5'd2, ALU_SLL = 5'd3,
                         ALU_SLT = 5'd4, ALU_SLTU = 5'd5, ALU_XOR = 5'd6, ALU_SRL = 5'd7,
                         ALU_SRA = 5'd8, ALU_OR = 5'd9, ALU_AND = 5'd10;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
    S_MEMORY = 3'd3, S_WRITEBACK = 3'd4, S_TRAP = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD
  } iclass_t;

  state_t            r_state, w_next_state;
  logic [WAIT_W-1:0] r_wait;
  logic [1:0]        r_cause, w_set_cause;
  logic [CNT_W-1:0]  r_count;
  iclass_t           w_class;
  logic              w_illegal, w_alusrc, w_timeout, w_retire;
  logic [4:0]        w_alu;
  logic [6:0]        w_opcode, w_f7;
  logic [2:0]        w_f3;
  logic              w_unused;

  assign w_opcode = instruction_code[6:0];
  assign w_f3     = instruction_code[14:12];
  assign w_f7     = instruction_code[31:25];
  assign w_unused = ^{instruction_code[24:15], instruction_code[11:7]};

  // Instruction class, legality and ALU decode from the instruction register.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_class   = C_BAD;
    w_illegal = 1'b0;
    w_alu     = ALU_NOP;
    w_alusrc  = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_class = C_R;
        case ({w_f7, w_f3})
          {7'b0000000, 3'b000}: w_alu = ALU_ADD;
          {7'b0100000, 3'b000}: w_alu = ALU_SUB;
          {7'b0000000, 3'b001}: w_alu = ALU_SLL;
          {7'b0000000, 3'b010}: w_alu = ALU_SLT;
          {7'b0000000, 3'b011}: w_alu = ALU_SLTU;
          {7'b0000000, 3'b100}: w_alu = ALU_XOR;
          {7'b0000000, 3'b101}: w_alu = ALU_SRL;
          {7'b0100000, 3'b101}: w_alu = ALU_SRA;
          {7'b0000000, 3'b110}: w_alu = ALU_OR;
          {7'b0000000, 3'b111}: w_alu = ALU_AND;
          default:              w_illegal = 1'b1;
        endcase
      end
      OP_I_ARITH: begin
        w_class  = C_I;
        w_alusrc = 1'b1;
        case (w_f3)
          3'b000: w_alu = ALU_ADD;
          3'b001: begin w_alu = ALU_SLL; w_illegal = (w_f7 != 7'b0000000); end
          3'b010: w_alu = ALU_SLT;
          3'b011: w_alu = ALU_SLTU;
          3'b100: w_alu = ALU_XOR;
          3'b101: begin
            w_alu     = w_f7[5] ? ALU_SRA : ALU_SRL;
            w_illegal = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
          end
          3'b110: w_alu = ALU_OR;
          default: w_alu = ALU_AND;
        endcase
      end
      OP_I_LOAD:  begin w_class = C_LOAD;   w_alu = ALU_ADD; w_alusrc = 1'b1; end
      OP_S:       begin w_class = C_STORE;  w_alu = ALU_ADD; w_alusrc = 1'b1; end
      OP_B:       begin w_class = C_BRANCH; w_alu = ALU_SUB; end
      OP_J_JAL:   w_class = C_JAL;
      OP_I_JALR:  begin w_class = C_JALR;   w_alu = ALU_ADD; w_alusrc = 1'b1; end
      OP_U_LUI:   begin w_class = C_LUI;    w_alu = ALU_ADD; w_alusrc = 1'b1; end
      OP_U_AUIPC: begin w_class = C_AUIPC;  w_alu = ALU_ADD; w_alusrc = 1'b1; end
      default:    w_illegal = 1'b1;
    endcase
  end

  // A ready in the last allowed wait cycle still completes the access.
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait == LAST_WAIT) && !mem_ready;

  always_comb begin
    w_next_state = r_state;
    w_set_cause  = 2'd0;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)      w_next_state = S_DECODE;
        else if (w_timeout) begin w_next_state = S_TRAP; w_set_cause = 2'd2; end
      end
      S_DECODE: begin
        if (w_illegal) begin w_next_state = S_TRAP; w_set_cause = 2'd1; end
        else           w_next_state = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (w_class)
          C_LOAD, C_STORE:        w_next_state = S_MEMORY;
          C_BRANCH, C_JAL, C_JALR: w_next_state = S_FETCH;
          default:                w_next_state = S_WRITEBACK;
        endcase
      end
      S_MEMORY: begin
        if (mem_ready)      w_next_state = (w_class == C_LOAD) ? S_WRITEBACK : S_FETCH;
        else if (w_timeout) begin w_next_state = S_TRAP; w_set_cause = 2'd2; end
      end
      S_WRITEBACK: w_next_state = S_FETCH;
      S_TRAP:      if (trap_clear) w_next_state = S_FETCH;
      default:     w_next_state = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
      r_cause <= 2'd0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state) r_wait <= '0;
      else if (!mem_ready)         r_wait <= r_wait + 1'b1;
      if (w_set_cause != 2'd0)                   r_cause <= w_set_cause;
      else if (r_state == S_TRAP && trap_clear)  r_cause <= 2'd0;
      if (w_retire) r_count <= r_count + 1'b1;
    end
  end

  // NOTE: strobes are forced low while reset is high so an in-flight request drops at once.
  always_comb begin
    PCWrite = 1'b0; PCSrc = 2'd0; IRWrite = 1'b0; IorD = 1'b0; MemRead = 1'b0;
    MemWrite = 1'b0; RegWrite = 1'b0; MemtoReg = 2'd0; ALUSrc = 1'b0;
    ALUControl = ALU_NOP; w_retire = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_EXECUTE: begin
        ALUControl = w_alu;
        ALUSrc     = w_alusrc;
        case (w_class)
          C_BRANCH: begin PCSrc = 2'd1; PCWrite = branch_taken; w_retire = 1'b1; end
          C_JAL, C_JALR: begin
            PCWrite  = 1'b1;
            PCSrc    = (w_class == C_JAL) ? 2'd2 : 2'd3;
            RegWrite = 1'b1;
            MemtoReg = 2'd2;
            w_retire = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEMORY: begin
        IorD     = 1'b1;
        MemRead  = (w_class == C_LOAD);
        MemWrite = (w_class == C_STORE);
        w_retire = (w_class == C_STORE) && mem_ready;
      end
      S_WRITEBACK: begin
        RegWrite = 1'b1;
        MemtoReg = (w_class == C_LOAD) ? 2'd1 : 2'd0;
        w_retire = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite = 1'b0; IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
      w_retire = 1'b0;
    end
  end

  assign state         = r_state;
  assign trap          = (r_state == S_TRAP) && !reset;
  assign trap_cause    = r_cause;
  assign instr_retired = w_retire;
  assign instret_count = r_count;

endmodule
